fifo_mc: RTL and testbench

FIFO_MC -- requirements
Module: fifo_mc

---
 rtl/fifo_mc_pkg.sv | 26 ++
 rtl/fifo_mc_ram_v3.sv | 29 ++
 rtl/fifo_mc.sv | 131 +++++++++++++
 tb/tb_fifo_mc.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_mc_pkg.sv
// fifo_mc_pkg: shared definitions for the multi-channel FIFO.
//   calc_ch_w : channel-index width, never less than one bit
//   calc_cw   : per-channel pointer/count width (one extra wrap bit)
//   ch_status_t : per-channel status bundle (full, empty, afull, count)
package fifo_mc_pkg;

  // Status count is carried at a fixed width so the struct stays
  // parameter-independent; channels are limited to DEPTH_WIDTH <= 15.
  localparam int unsigned MAX_CW = 16;

  typedef struct packed {
    logic              full;
    logic              empty;
    logic              afull;
    logic [MAX_CW-1:0] count;
  } ch_status_t;

  function automatic int unsigned calc_ch_w(input int unsigned num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  function automatic int unsigned calc_cw(input int unsigned depth_width);
    return depth_width + 1;
  endfunction

endpackage

// File: rtl/fifo_mc_ram_v3.sv
// ram_v3: simple dual-port synchronous RAM, one write port, one read port
// with a registered (1-cycle) read. No reset; contents are undefined until
// written.
//   clk   : clock
//   we    : write enable      waddr/wdata : write address / data
//   re    : read enable       raddr       : read address
//   rdata : read data, valid the cycle after re, held otherwise
module ram_v3 #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_mc.sv
// fifo_mc: NUM_CH independent FIFOs sharing one statically partitioned RAM.
//   clk, rst_n (sync, active-low)
//   wr_en_i/wr_ch_i/wr_data_i : push request
//   rd_en_i/rd_ch_i           : pop request
//   rd_valid_o/rd_data_o/rd_ch_o : popped entry, one cycle after accept
//   full_o/empty_o/afull_o/count_o : per-channel status from pointers
//   ovf_o/udf_o : sticky dropped-write / dropped-read flags
module fifo_mc
  import fifo_mc_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DEPTH_WIDTH = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned AF_THRESH   = (32'd1 << DEPTH_WIDTH) - 32'd1,
  localparam int unsigned CH_W = calc_ch_w(NUM_CH),
  localparam int unsigned CW   = calc_cw(DEPTH_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic [CH_W-1:0]        wr_ch_i,
  input  logic [DATA_WIDTH-1:0]  wr_data_i,
  input  logic                   rd_en_i,
  input  logic [CH_W-1:0]        rd_ch_i,
  output logic                   rd_valid_o,
  output logic [DATA_WIDTH-1:0]  rd_data_o,
  output logic [CH_W-1:0]        rd_ch_o,
  output logic [NUM_CH-1:0]      full_o,
  output logic [NUM_CH-1:0]      empty_o,
  output logic [NUM_CH-1:0]      afull_o,
  output logic [NUM_CH*CW-1:0]   count_o,
  output logic [NUM_CH-1:0]      ovf_o,
  output logic [NUM_CH-1:0]      udf_o
);

  localparam int unsigned AW = CH_W + DEPTH_WIDTH;

  logic [CW-1:0]          wr_ptr [NUM_CH];
  logic [CW-1:0]          rd_ptr [NUM_CH];
  logic [CW-1:0]          cnt    [NUM_CH];
  ch_status_t             st     [NUM_CH];
  logic [NUM_CH-1:0]      wr_hit, rd_hit;
  logic                   wr_acc, rd_acc;
  logic [DEPTH_WIDTH-1:0] wr_lo, rd_lo;
  logic [DATA_WIDTH-1:0]  ram_rdata;

  // Status from pointer registers only (pre-edge state, no bypass).
  always_comb begin
    full_o  = '0;
    empty_o = '0;
    afull_o = '0;
    count_o = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      st[i]       = '0;
      cnt[i]      = wr_ptr[i] - rd_ptr[i];
      st[i].count = MAX_CW'(cnt[i]);
      st[i].empty = (wr_ptr[i] == rd_ptr[i]);
      st[i].full  = (wr_ptr[i][CW-2:0] == rd_ptr[i][CW-2:0]) &&
                    (wr_ptr[i][CW-1] != rd_ptr[i][CW-1]);
      st[i].afull = (32'(st[i].count) >= AF_THRESH);
      full_o[i]   = st[i].full;
      empty_o[i]  = st[i].empty;
      afull_o[i]  = st[i].afull;
      count_o[i*CW +: CW] = st[i].count[CW-1:0];
    end
  end

  // One-hot channel decode; an out-of-range channel matches nothing, so
  // the request is dropped without touching pointers or flags.
  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    wr_lo  = '0;
    rd_lo  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = wr_en_i && (wr_ch_i == CH_W'(i));
      rd_hit[i] = rd_en_i && (rd_ch_i == CH_W'(i));
      if (wr_hit[i]) wr_lo = wr_ptr[i][DEPTH_WIDTH-1:0];
      if (rd_hit[i]) rd_lo = rd_ptr[i][DEPTH_WIDTH-1:0];
    end
    wr_acc = |(wr_hit & ~full_o);
    rd_acc = |(rd_hit & ~empty_o);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      ovf_o      <= '0;
      udf_o      <= '0;
      rd_valid_o <= 1'b0;
      rd_ch_o    <= '0;
    end else begin
      rd_valid_o <= rd_acc;
      if (rd_acc) rd_ch_o <= rd_ch_i;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (wr_hit[i]) begin
          if (full_o[i]) ovf_o[i] <= 1'b1;
          else           wr_ptr[i] <= wr_ptr[i] + 1'b1;
        end
        if (rd_hit[i]) begin
          if (empty_o[i]) udf_o[i] <= 1'b1;
          else            rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
      end
    end
  end

  // Accepted write and read never share an address: a shared slot means
  // the channel is empty (read refused) or full (write refused).
  ram_v3 #(
    .DEPTH  (NUM_CH << DEPTH_WIDTH),
    .ADDR_W (AW),
    .DATA_W (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr ({wr_ch_i, wr_lo}),
    .wdata (wr_data_i),
    .re    (rd_acc),
    .raddr ({rd_ch_i, rd_lo}),
    .rdata (ram_rdata)
  );

  // RAM output register is not reset; gating keeps data zero when idle
  // and after reset.
  assign rd_data_o = rd_valid_o ? ram_rdata : '0;

endmodule

// File: tb/tb_fifo_mc.sv
// tb_fifo_mc: directed scoreboard bench for fifo_mc (4 ch, depth 4, 8-bit).
module tb_fifo_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [1:0]  wr_ch, rd_ch;
  logic [7:0]  wr_data;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [1:0]  rd_ch_q;
  logic [3:0]  full, empty, afull, ovf, udf;
  logic [11:0] count;

  fifo_mc #(
    .NUM_CH      (4),
    .DEPTH_WIDTH (2),
    .DATA_WIDTH  (8),
    .AF_THRESH   (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_ch_i    (wr_ch),
    .wr_data_i  (wr_data),
    .rd_en_i    (rd_en),
    .rd_ch_i    (rd_ch),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .rd_ch_o    (rd_ch_q),
    .full_o     (full),
    .empty_o    (empty),
    .afull_o    (afull),
    .count_o    (count),
    .ovf_o      (ovf),
    .udf_o      (udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   nchk  = 0;
  int   nfail = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [2:0] cnt_of(input int ch);
    return count[ch*3 +: 3];
  endfunction

  // Monitor: compares every presented output against the scoreboard.
  always @(negedge clk) begin
    if (rst_n !== 1'b0 || rd_valid) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rd_valid", 32'(rd_data), 32'hDEAD);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rd_latency", 32'(cyc), 32'(e.due));
          chk("rd_data", 32'(rd_data), 32'(e.data));
          chk("rd_ch", 32'(rd_ch_q), 32'(e.ch));
        end
      end else begin
        chk("rd_data_idle_zero", 32'(rd_data), 32'h0);
        if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rd_valid_missing", 32'(rd_valid), 32'h1);
        end
      end
    end
  end

  // One clock of stimulus; exp_rd pushes the hand-computed popped value.
  task automatic op(input logic we, input logic [1:0] wch, input logic [7:0] wd,
                    input logic re, input logic [1:0] rch,
                    input logic exp_rd, input logic [7:0] exp_d);
    exp_t e;
    if (exp_rd) begin
      e.due  = cyc + 1;
      e.ch   = rch;
      e.data = exp_d;
      exp_q.push_back(e);
    end
    wr_en = we; wr_ch = wch; wr_data = wd;
    rd_en = re; rd_ch = rch;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] d);
    op(1'b1, ch, d, 1'b0, 2'd0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [1:0] ch, input logic [7:0] exp_d);
    op(1'b0, 2'd0, 8'h00, 1'b1, ch, 1'b1, exp_d);
  endtask

  task automatic idle();
    op(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_ch = '0; rd_ch = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_valid", 32'(rd_valid), 32'h0);
    chk("reset_empty", 32'(empty), 32'hF);
    chk("reset_full", 32'(full), 32'h0);
    chk("reset_afull", 32'(afull), 32'h0);
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_flags", 32'({ovf, udf}), 32'h0);
    rst_n = 1'b1;
    idle();

    // Fill ch2 to full, then overflow.
    wr(2'd2, 8'h11);
    wr(2'd2, 8'h22);
    chk("afull_after_2", 32'(afull), 32'h0);
    wr(2'd2, 8'h33);
    chk("afull_after_3", 32'(afull), 32'h4);
    wr(2'd2, 8'h44);
    chk("full_ch2", 32'(full), 32'h4);
    chk("count_ch2_full", 32'(cnt_of(2)), 32'd4);
    wr(2'd2, 8'h55);
    chk("ovf_ch2", 32'(ovf), 32'h4);
    chk("count_ch2_after_drop", 32'(cnt_of(2)), 32'd4);

    // Drain ch2 back-to-back.
    rd(2'd2, 8'h11);
    rd(2'd2, 8'h22);
    rd(2'd2, 8'h33);
    rd(2'd2, 8'h44);
    idle();
    chk("empty_after_drain", 32'(empty), 32'hF);

    // Read empty ch0 with simultaneous write: no bypass.
    op(1'b1, 2'd0, 8'hA5, 1'b1, 2'd0, 1'b0, 8'h00);
    chk("udf_ch0", 32'(udf), 32'h1);
    chk("count_ch0_one", 32'(cnt_of(0)), 32'd1);
    rd(2'd0, 8'hA5);

    // Interleaved channels stay independent.
    wr(2'd1, 8'h01);
    wr(2'd3, 8'h03);
    wr(2'd1, 8'h02);
    wr(2'd3, 8'h04);
    rd(2'd3, 8'h03);
    rd(2'd1, 8'h01);
    chk("count_ch1_one", 32'(cnt_of(1)), 32'd1);
    chk("count_ch3_one", 32'(cnt_of(3)), 32'd1);
    rd(2'd3, 8'h04);
    wr(2'd1, 8'h12);
    wr(2'd1, 8'h13);
    chk("count_ch1_three", 32'(cnt_of(1)), 32'd3);

    // Steady push/pop at count 2 across pointer wrap.
    wr(2'd0, 8'hB0);
    wr(2'd0, 8'hB1);
    for (int k = 0; k < 12; k++) begin
      logic [7:0] ed;
      ed = (k == 0) ? 8'hB0 : (k == 1) ? 8'hB1 : 8'(8'hC0 + k - 2);
      op(1'b1, 2'd0, 8'(8'hC0 + k), 1'b1, 2'd0, 1'b1, ed);
      chk("count_ch0_steady", 32'(cnt_of(0)), 32'd2);
    end
    rd(2'd0, 8'hCA);
    rd(2'd0, 8'hCB);
    chk("empty_ch0_after_wrap", 32'(empty[0]), 32'h1);
    chk("ovf_sticky", 32'(ovf), 32'h4);

    // Reset with ch1 holding 3 entries and a read just accepted.
    rd(2'd1, 8'h02);
    rst_n = 1'b0;
    rd_en = 1'b1; rd_ch = 2'd1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    chk("midreset_rd_valid", 32'(rd_valid), 32'h0);
    chk("midreset_empty", 32'(empty), 32'hF);
    chk("midreset_flags", 32'({ovf, udf}), 32'h0);
    chk("midreset_count", 32'(count), 32'h0);
    rst_n = 1'b1;
    idle();
    wr(2'd1, 8'h77);
    chk("post_reset_count_ch1", 32'(cnt_of(1)), 32'd1);
    rd(2'd1, 8'h77);

    repeat (3) idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
